flag_scan_engine: RTL and testbench

- Parametrised sequential priority scanner. Latches a WIDTH-bit flag vector and searches it CHUNK bits per clock for the first set bit, either LSB-first or MSB-first.
- Stops early on the first hit and reports its index.
- Supports a find-next operation that resumes past the last hit, so every set bit can be enumerated in turn.
- Serves as a shared utility block for status/flag registers in the datapath.

---
 rtl/flag_scan_engine.sv | 181 ++++++++++++++++++
 tb/tb_flag_scan_engine.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_scan_engine.sv
// flag_scan_engine
//   Sequential priority scanner for status/flag registers. A WIDTH-bit vector
//   is latched on start and searched CHUNK bits per clock for the first set
//   bit, LSB-first or MSB-first. The scan stops on the first hit. A find-next
//   operation resumes past the last hit, so every set bit can be enumerated.
//
// Ports
//   clock      system clock, rising edge
//   reset_n    synchronous active-low reset
//   start      begin a new scan of flag_in (taken only when idle)
//   flag_in    vector to scan, sampled on the accepting edge
//   msb_first  scan order, sampled with start (0: bit 0 up, 1: bit WIDTH-1 down)
//   next       resume after the last hit (idle, found, valid and no start)
//   busy       scan in progress
//   done       one-cycle pulse when a scan completes
//   valid      a result is available (cleared by reset and by accepted start/next)
//   found      result: a set bit was located
//   index      result: bit position of the hit, 0 when found=0
//
// state | meaning
// IDLE  | waiting for start or next; result outputs hold
// SCAN  | examining one chunk per cycle, chunk pointer k in scan order

module flag_scan_engine #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] flag_in,
  input  logic             msb_first,
  input  logic             next,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int K_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NCH - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shadow, shadow_nxt;
  logic             dir, dir_nxt;
  logic [K_W-1:0]   k, k_nxt;
  logic             busy_nxt, done_nxt, valid_nxt, found_nxt;
  logic [IDX_W-1:0] index_nxt;

  // Shadow re-ordered so that scan position p is always bit p; both
  // directions then share one LSB-first chunk search.
  logic [WIDTH-1:0] ordered;
  logic [IDX_W-1:0] chunk_base;
  logic [CHUNK-1:0] chunk_bits;
  logic             hit;
  int               hit_j;
  int               hit_pos;
  logic [IDX_W-1:0] hit_idx;

  // Find-next support: scan position of the last hit and the bits to drop.
  logic [IDX_W-1:0] cur_pos;
  logic [WIDTH-1:0] clr_mask;
  logic [K_W-1:0]   resume_k;

  always_comb begin
    ordered = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ordered[i] = dir ? shadow[WIDTH-1-i] : shadow[i];
    end
  end

  always_comb begin
    chunk_base = IDX_W'(int'(k) * CHUNK);
    chunk_bits = ordered[chunk_base +: CHUNK];
    hit        = |chunk_bits;
    hit_j      = 0;
    // Walk downward so the lowest set position wins.
    for (int j = CHUNK - 1; j >= 0; j--) begin
      if (chunk_bits[j]) hit_j = j;
    end
    hit_pos = int'(k) * CHUNK + hit_j;
    hit_idx = dir ? IDX_W'(WIDTH - 1 - hit_pos) : IDX_W'(hit_pos);
  end

  always_comb begin
    cur_pos  = dir ? (IDX_W'(WIDTH - 1) - index) : index;
    resume_k = K_W'(int'(cur_pos) / CHUNK);
    clr_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      clr_mask[i] = dir ? (IDX_W'(i) >= index) : (IDX_W'(i) <= index);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      shadow <= '0;
      dir    <= 1'b0;
      k      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      valid  <= 1'b0;
      found  <= 1'b0;
      index  <= '0;
    end else begin
      state  <= state_nxt;
      shadow <= shadow_nxt;
      dir    <= dir_nxt;
      k      <= k_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      valid  <= valid_nxt;
      found  <= found_nxt;
      index  <= index_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    dir_nxt    = dir;
    k_nxt      = k;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    valid_nxt  = valid;
    found_nxt  = found;
    index_nxt  = index;

    case (state)
      IDLE: begin
        if (start) begin
          shadow_nxt = flag_in;
          dir_nxt    = msb_first;
          k_nxt      = '0;
          busy_nxt   = 1'b1;
          valid_nxt  = 1'b0;
          found_nxt  = 1'b0;
          index_nxt  = '0;
          state_nxt  = SCAN;
        end else if (next && found && valid) begin
          // Direction is kept from the original start.
          shadow_nxt = shadow & ~clr_mask;
          k_nxt      = resume_k;
          busy_nxt   = 1'b1;
          valid_nxt  = 1'b0;
          found_nxt  = 1'b0;
          index_nxt  = '0;
          state_nxt  = SCAN;
        end
      end

      SCAN: begin
        if (hit) begin
          index_nxt = hit_idx;
          found_nxt = 1'b1;
          done_nxt  = 1'b1;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (k == K_LAST) begin
          index_nxt = '0;
          found_nxt = 1'b0;
          done_nxt  = 1'b1;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          k_nxt = k + K_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_flag_scan_engine.sv
module tb_flag_scan_engine;

  localparam int W   = 16;
  localparam int C   = 4;
  localparam int NCH = W / C;

  logic         clock = 1'b0;
  logic         reset_n, start, msb_first, next;
  logic [W-1:0] flag_in;
  logic         busy, done, valid, found;
  logic [3:0]   index;

  // Extra instances for chunk-size latency checks.
  logic         start1, start16;
  logic [W-1:0] flag_x;
  logic         busy1, done1, valid1, found1;
  logic [3:0]   index1;
  logic         busy16, done16, valid16, found16;
  logic [3:0]   index16;
  logic         zero_b = 1'b0;

  always #5 clock = ~clock;

  flag_scan_engine #(.WIDTH(W), .CHUNK(C)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .flag_in(flag_in),
    .msb_first(msb_first), .next(next), .busy(busy), .done(done),
    .valid(valid), .found(found), .index(index));

  flag_scan_engine #(.WIDTH(W), .CHUNK(1)) dut_c1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .flag_in(flag_x),
    .msb_first(zero_b), .next(zero_b), .busy(busy1), .done(done1),
    .valid(valid1), .found(found1), .index(index1));

  flag_scan_engine #(.WIDTH(W), .CHUNK(16)) dut_c16 (
    .clock(clock), .reset_n(reset_n), .start(start16), .flag_in(flag_x),
    .msb_first(zero_b), .next(zero_b), .busy(busy16), .done(done16),
    .valid(valid16), .found(found16), .index(index16));

  int cyc = 0;
  always @(posedge clock) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit f;
    int idx;
    int at;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no scan outstanding (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("found", int'(found), int'(e.f));
        chk("index", int'(index), e.idx);
        chk("done_cycle", cyc, e.at);
        chk("valid_at_done", int'(valid), 1);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  // Reference model: vector held in scan-position terms via helpers.
  logic [W-1:0] m_vec;
  bit           m_dir, m_found, m_valid;
  int           m_pos, m_idx;

  function automatic bit bit_at(input logic [W-1:0] v, input bit d, input int p);
    return d ? v[W-1-p] : v[p];
  endfunction

  function automatic int first_from(input logic [W-1:0] v, input bit d, input int from);
    for (int p = from; p < W; p++) if (bit_at(v, d, p)) return p;
    return -1;
  endfunction

  function automatic int pos_to_idx(input bit d, input int p);
    return d ? (W - 1 - p) : p;
  endfunction

  task automatic wait_idle();
    for (int n = 0; n < 64; n++) begin
      #1;
      if (busy === 1'b0 && q.size() == 0) return;
      @(negedge clock);
    end
    checks++;
    errors++;
    $display("FAIL wait_idle_timeout: busy=%0b pending=%0d", busy, q.size());
    q.delete();
  endtask

  task automatic hold_check();
    chk("hold_found", int'(found), int'(m_found));
    chk("hold_index", int'(index), m_found ? m_idx : 0);
    chk("hold_valid", int'(valid), int'(m_valid));
  endtask

  task automatic issue_start(input logic [W-1:0] f, input bit d, input bit with_next);
    exp_t e;
    int p;
    @(negedge clock);
    start = 1'b1; next = with_next; flag_in = f; msb_first = d;
    m_vec = f; m_dir = d;
    p = first_from(m_vec, m_dir, 0);
    e.f = (p >= 0);
    e.idx = (p >= 0) ? pos_to_idx(d, p) : 0;
    e.at = cyc + 1 + ((p >= 0) ? (p / C + 1) : NCH);
    q.push_back(e);
    m_found = e.f; m_idx = e.idx; m_pos = p; m_valid = 1'b1;
    @(negedge clock);
    start = 1'b0; next = 1'b0;
    flag_in = W'($urandom);
    chk("start_busy", int'(busy), 1);
    chk("start_valid_clr", int'(valid), 0);
    wait_idle();
    hold_check();
  endtask

  task automatic issue_next();
    exp_t e;
    int p, base;
    bit acc;
    @(negedge clock);
    next = 1'b1;
    acc = m_found && m_valid;
    if (acc) begin
      for (int i = 0; i <= m_pos; i++) begin
        if (m_dir) m_vec[W-1-i] = 1'b0; else m_vec[i] = 1'b0;
      end
      base = m_pos / C;
      p = first_from(m_vec, m_dir, m_pos + 1);
      e.f = (p >= 0);
      e.idx = (p >= 0) ? pos_to_idx(m_dir, p) : 0;
      e.at = cyc + 1 + ((p >= 0) ? (p / C - base + 1) : (NCH - base));
      q.push_back(e);
      m_found = e.f; m_idx = e.idx; m_pos = p;
    end
    @(negedge clock);
    next = 1'b0;
    if (acc) begin
      chk("next_busy", int'(busy), 1);
      chk("next_valid_clr", int'(valid), 0);
      wait_idle();
    end else begin
      chk("ignored_next_busy", int'(busy), 0);
    end
    hold_check();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    int t0, at1, at16;
    reset_n = 1'b0; start = 1'b0; next = 1'b0; flag_in = '0; msb_first = 1'b0;
    start1 = 1'b0; start16 = 1'b0; flag_x = 16'h2000;
    m_vec = '0; m_dir = 0; m_found = 0; m_valid = 0; m_pos = -1; m_idx = 0;
    repeat (3) @(negedge clock);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_found", int'(found), 0);
    chk("rst_index", int'(index), 0);
    reset_n = 1'b1;

    issue_next();                           // no result yet: ignored
    issue_start(16'h2000, 1'b0, 1'b0);      // idx 13 after 4
    issue_start(16'h2001, 1'b1, 1'b0);      // idx 13 after 1
    issue_next();                           // idx 0 after 4
    issue_next();                           // miss after 1
    issue_next();                           // ignored
    issue_start(16'h0000, 1'b0, 1'b0);
    issue_start(16'h0000, 1'b1, 1'b0);
    issue_start(16'h8421, 1'b0, 1'b0);
    repeat (4) issue_next();                // 5, 10, 15, miss

    // Reset mid-scan: sampled at E0+2, no done may follow.
    @(negedge clock);
    start = 1'b1; flag_in = 16'h8000; msb_first = 1'b0;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_valid", int'(valid), 0);
    chk("abort_found", int'(found), 0);
    chk("abort_index", int'(index), 0);
    reset_n = 1'b1;
    m_found = 0; m_valid = 0; m_idx = 0;
    repeat (5) @(negedge clock);
    issue_next();
    issue_start(16'h8000, 1'b0, 1'b0);

    // start and flag_in activity while busy must not disturb the scan.
    @(negedge clock);
    start = 1'b1; flag_in = 16'h2000; msb_first = 1'b0;
    begin
      exp_t e;
      e.f = 1; e.idx = 13; e.at = cyc + 1 + 4;
      q.push_back(e);
    end
    m_vec = 16'h2000; m_dir = 0; m_found = 1; m_idx = 13; m_pos = 13; m_valid = 1;
    @(negedge clock);
    flag_in = 16'h0001; msb_first = 1'b1;
    @(negedge clock);
    start = 1'b0; flag_in = 16'hFFFF;
    wait_idle();
    hold_check();

    // Simultaneous start and next in idle: start wins.
    issue_start(16'h0010, 1'b0, 1'b0);
    issue_start(16'h0100, 1'b0, 1'b1);

    // Randomised mix.
    for (int n = 0; n < 120; n++) begin
      if (m_found && m_valid && $urandom_range(0, 2) != 0) begin
        issue_next();
      end else if ($urandom_range(0, 6) == 0) begin
        issue_next();
      end else begin
        v = W'($urandom);
        if ($urandom_range(0, 1) == 0) v = v & W'($urandom) & W'($urandom);
        if ($urandom_range(0, 9) == 0) v = '0;
        issue_start(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      end
    end

    // Chunk size 1 and 16 on 16'h2000.
    @(negedge clock);
    t0 = cyc;
    start1 = 1'b1; start16 = 1'b1;
    @(negedge clock);
    start1 = 1'b0; start16 = 1'b0;
    at1 = -1; at16 = -1;
    for (int n = 0; n < 40 && (at1 < 0 || at16 < 0); n++) begin
      if (done1 === 1'b1 && at1 < 0) begin
        at1 = cyc;
        chk("c1_found", int'(found1), 1);
        chk("c1_index", int'(index1), 13);
      end
      if (done16 === 1'b1 && at16 < 0) begin
        at16 = cyc;
        chk("c16_found", int'(found16), 1);
        chk("c16_index", int'(index16), 13);
      end
      @(negedge clock);
    end
    chk("c1_done_cycle", at1, t0 + 1 + 14);
    chk("c16_done_cycle", at16, t0 + 1 + 1);

    repeat (3) @(negedge clock);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
